irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Collects NUM_SRC external interrupt lines, masks them, and picks one by fixed priority.
//  Injects that interrupt into the exception unit at a safe MEM-stage boundary. Drives its
//  `interrupt` input and supplies the mcause code for the taken source.
//  Blocks nesting: once an interrupt is taken, nothing new is taken until the handler's mret.
// PARAMETERS
//  NUM_SRC     4        number of interrupt sources (1..16); source 0 = highest priority
//  EDGE_MASK   4'b0000  per-source trigger mode: 1 = rising-edge, 0 = level-high
//  CAUSE_BASE  16       mcause code of source 0; source i reports CAUSE_BASE+i (fits 8 bits)
// PORTS
//  clk            in   1        core clock, rising edge
//  rst            in   1        reset, asynchronous, active-high
//  irq_src        in   NUM_SRC  raw interrupt lines, asynchronous to clk
//  irq_enable     in   NUM_SRC  per-source enable (mie bits)
//  mie_global     in   1        mstatus.MIE
//  inst_valid_mem in   1        MEM holds a real, interruptible instruction (not a bubble)
//  stall          in   1        pipeline stalled this cycle
//  exception_mem  in   1        synchronous exception present in MEM this cycle
//  mret           in   1        mret retiring this cycle
//  interrupt      out  1        take interrupt now (to exception unit)
//  irq_code       out  8        mcause[7:0] of the taken source; valid while interrupt=1
//  irq_ack        out  NUM_SRC  one-hot pulse to the taken source, same cycle as interrupt
//  in_handler     out  1        an interrupt is taken and its mret has not been seen
// BEHAVIOUR
//  - Reset: all flops cleared, state=IDLE. interrupt=0, irq_code=0, irq_ack=0, in_handler=0.
//  - Sync: each irq_src goes through 2 flops (s1,s2), plus s3 = s2 delayed one cycle.
//  - Raw request per source i:
//    - level: req_i = s2_i.
//    - edge: req_i = pend_i | (s2_i & ~s3_i).
//    - pend_i sets on a detected edge and clears only on irq_ack_i.
//  - Eligibility: elig_i = req_i & irq_enable_i & mie_global. Lowest index among elig wins.
//  - FSM, registered state:
//    - IDLE: any elig -> ARMED at the next edge; latch sel = winner index.
//    - ARMED, sel unchanged while ARMED:
//      - fire = elig_sel & inst_valid_mem & ~stall & ~exception_mem.
//      - If fire: interrupt=1, irq_code=CAUSE_BASE+sel, irq_ack[sel]=1 (all combinational); -> HANDLER.
//      - elif !elig_sel (source dropped or masked): -> IDLE, nothing output.
//      - else stay ARMED.
//    - HANDLER: in_handler=1. mret -> IDLE at next edge. All other inputs ignored.
//  - Outputs outside ARMED/fire: interrupt=0, irq_code=0, irq_ack=0.
//  - Latency: irq_src rises before edge E1 -> s2=1 after E2 -> ARMED after E3.
//    Earliest interrupt=1 is in the cycle after E3.
//  - Exceptions win: exception_mem=1 suppresses fire; FSM stays ARMED.
//  - mret arriving in IDLE or ARMED is ignored.
//  - A higher-priority source arriving while ARMED does not preempt sel. It is served after mret.
//  - An edge on a source while HANDLER is held in pend_i, not lost. A second edge before ack merges.
//  - Level source still high after mret is retaken (device must deassert on irq_ack).
//  - Async rst mid-ARMED or mid-HANDLER clears state and pend; outputs drop immediately.
// TESTING
//  1 Level src2 high, enable=4'hF, mie_global=1, inst_valid_mem=1 -> interrupt=1 in cycle 4
//    after assert, irq_code=18, irq_ack=4'b0100, in_handler=1 the cycle after.
//  2 src1 and src3 asserted together -> irq_code=17. src3 taken only after mret,
//    with irq_code=19.
//  3 ARMED with stall=1 for 5 cycles, then exception_mem=1 for 1 cycle -> interrupt=0 throughout;
//    fires on the first clean cycle.
//  4 EDGE_MASK=4'b0001: 1-cycle pulse on src0 while in_handler -> pend0 held;
//    after mret, interrupt with irq_code=16.
//  5 Level src2 drops while ARMED (inst_valid_mem=0) -> back to IDLE, no interrupt, no ack.
//    mie_global=0 -> never leaves IDLE.
//  6 rst asserted while HANDLER -> in_handler=0 asynchronously; pending edge lost; IDLE after release.

Source files
------------

// File: rtl/irq_arbiter_if.sv
// Interrupt arbiter bus: raw interrupt lines and pipeline status in,
// interrupt request, cause code, acknowledges and handler status out.
interface irq_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] irq_enable;
    logic               mie_global;
    logic               inst_valid_mem;
    logic               stall;
    logic               exception_mem;
    logic               mret;
    logic               interrupt;
    logic [7:0]         irq_code;
    logic [NUM_SRC-1:0] irq_ack;
    logic               in_handler;

    // Core / device side: drives the interrupt lines and pipeline status.
    modport master (
        output irq_src, irq_enable, mie_global, inst_valid_mem, stall,
               exception_mem, mret,
        input  interrupt, irq_code, irq_ack, in_handler
    );

    // Arbiter side.
    modport slave (
        input  irq_src, irq_enable, mie_global, inst_valid_mem, stall,
               exception_mem, mret,
        output interrupt, irq_code, irq_ack, in_handler
    );
endinterface

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter. Synchronises the raw interrupt lines,
// latches rising edges for edge-mode sources, picks the lowest-index eligible
// source and injects it at a clean MEM-stage boundary. No nesting: once taken,
// nothing new is accepted until mret.
module irq_arbiter #(
    parameter int                 NUM_SRC    = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK  = '0,
    parameter int                 CAUSE_BASE = 16
) (
    input  logic         clk,
    input  logic         rst,
    irq_arbiter_if.slave bus
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0] s1, s2, s3;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] elig;
    logic [SEL_W-1:0]   winner;
    logic               any_elig;
    logic               fire;

    // Two-flop synchroniser on the raw lines, plus a third stage for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= bus.irq_src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edge-mode pending bits: set by a synchronised rising edge, held until acknowledged.
    // Repeated edges before the ack merge into a single request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend | rise) & ~bus.irq_ack & EDGE_MASK;
        end
    end

    // Request, eligibility and fixed-priority pick (lowest index wins).
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        rise     = s2 & ~s3;
        req      = (EDGE_MASK & (pend | rise)) | (~EDGE_MASK & s2);
        elig     = req & bus.irq_enable & {NUM_SRC{bus.mie_global}};
        any_elig = |elig;
        winner   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) winner = SEL_W'(i);
        end
    end

    // Take the armed source only on a real, unstalled, exception-free MEM instruction.
    always_comb begin
        fire = (state == ARMED) && elig[sel] && bus.inst_valid_mem &&
               !bus.stall && !bus.exception_mem;
    end

    // Control FSM: arm on any eligible source, fire or abandon, then wait for mret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state <= ARMED;
                        sel   <= winner;
                    end
                end
                ARMED: begin
                    if (fire) begin
                        state <= HANDLER;
                    end else if (!elig[sel]) begin
                        state <= IDLE;
                    end
                end
                HANDLER: begin
                    if (bus.mret) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs: interrupt, cause and ack appear combinationally in the firing cycle only.
    always_comb begin
        bus.interrupt  = fire;
        bus.irq_code   = fire ? 8'(CAUSE_BASE + int'(sel)) : 8'd0;
        bus.irq_ack    = '0;
        if (fire) bus.irq_ack[sel] = 1'b1;
        bus.in_handler = (state == HANDLER);
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the interrupt-taking rules.
module tb_irq_arbiter;
    localparam int         N  = 4;
    localparam logic [3:0] EM = 4'b0001;
    localparam int         CB = 16;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    irq_arbiter_if #(.NUM_SRC(N)) bus ();

    irq_arbiter #(
        .NUM_SRC   (N),
        .EDGE_MASK (EM),
        .CAUSE_BASE(CB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist1/2/3: line values seen at the last three clock edges.
    logic [N-1:0] hist1, hist2, hist3;
    logic [N-1:0] m_pend;
    bit           m_armed, m_hand;
    logic [1:0]   m_sel;

    logic [N-1:0] m_req, m_elig;
    logic [1:0]   m_win;
    bit           m_fire;
    logic         exp_int;
    logic [7:0]   exp_code;
    logic [N-1:0] exp_ack;

    always_comb begin
        m_req  = '0;
        m_elig = '0;
        m_win  = '0;
        for (int i = 0; i < N; i++) begin
            if (EM[i]) m_req[i] = m_pend[i] | (hist2[i] & ~hist3[i]);
            else       m_req[i] = hist2[i];
            m_elig[i] = m_req[i] & bus.irq_enable[i] & bus.mie_global;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (m_elig[i]) m_win = 2'(i);
        end
        m_fire   = m_armed && m_elig[m_sel] && bus.inst_valid_mem &&
                   !bus.stall && !bus.exception_mem;
        exp_int  = m_fire;
        exp_code = m_fire ? 8'(CB + int'(m_sel)) : 8'd0;
        exp_ack  = m_fire ? 4'(1 << m_sel) : 4'd0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist1   <= '0;
            hist2   <= '0;
            hist3   <= '0;
            m_pend  <= '0;
            m_armed <= 1'b0;
            m_hand  <= 1'b0;
            m_sel   <= '0;
        end else begin
            if (m_hand) begin
                if (bus.mret) m_hand <= 1'b0;
            end else if (m_armed) begin
                if (m_fire) begin
                    m_armed <= 1'b0;
                    m_hand  <= 1'b1;
                end else if (!m_elig[m_sel]) begin
                    m_armed <= 1'b0;
                end
            end else if (m_elig != 0) begin
                m_armed <= 1'b1;
                m_sel   <= m_win;
            end
            m_pend <= (m_pend | (hist2 & ~hist3 & EM)) & ~exp_ack;
            hist1  <= bus.irq_src;
            hist2  <= hist1;
            hist3  <= hist2;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("interrupt",  32'(bus.interrupt),  32'(exp_int));
        check("irq_code",   32'(bus.irq_code),   32'(exp_code));
        check("irq_ack",    32'(bus.irq_ack),    32'(exp_ack));
        check("in_handler", 32'(bus.in_handler), 32'(m_hand));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_mret();
        bus.mret = 1'b1;
        step(1);
        bus.mret = 1'b0;
    endtask

    // Outputs of the current cycle against hand-computed literals.
    task automatic pin_out(input string name, input logic i, input logic [7:0] c, input logic [3:0] a);
        #1;
        check({name, "_interrupt"}, 32'(bus.interrupt), 32'(i));
        check({name, "_irq_code"},  32'(bus.irq_code),  32'(c));
        check({name, "_irq_ack"},   32'(bus.irq_ack),   32'(a));
    endtask

    initial begin
        rst                = 1'b1;
        bus.irq_src        = '0;
        bus.irq_enable     = 4'hF;
        bus.mie_global     = 1'b1;
        bus.inst_valid_mem = 1'b1;
        bus.stall          = 1'b0;
        bus.exception_mem  = 1'b0;
        bus.mret           = 1'b0;
        step(2);
        rst = 1'b0;
        pin_out("reset", 1'b0, 8'd0, 4'd0);
        check("reset_in_handler", 32'(bus.in_handler), 32'd0);

        // 1: level src2 -> interrupt in the cycle after the third edge.
        step(1);
        bus.irq_src = 4'b0100;
        step(2);
        pin_out("t1_early", 1'b0, 8'd0, 4'd0);
        step(1);
        pin_out("t1_take", 1'b1, 8'd18, 4'b0100);
        check("t1_model_int", 32'(exp_int), 32'd1);
        step(1);
        check("t1_in_handler", 32'(bus.in_handler), 32'd1);
        bus.irq_src = 4'b0000;
        step(4);
        pulse_mret();
        step(3);

        // 2: src1 and src3 together -> src1 first, src3 after mret.
        bus.irq_src = 4'b1010;
        step(3);
        pin_out("t2_first", 1'b1, 8'd17, 4'b0010);
        step(1);
        bus.irq_src = 4'b1000;
        step(3);
        pulse_mret();
        pin_out("t2_idle", 1'b0, 8'd0, 4'd0);
        step(1);
        pin_out("t2_second", 1'b1, 8'd19, 4'b1000);
        step(1);
        bus.irq_src = 4'b0000;
        step(3);
        pulse_mret();
        step(3);

        // 3: stall then exception hold the armed source; fires on first clean cycle.
        bus.stall   = 1'b1;
        bus.irq_src = 4'b0100;
        step(3);
        pin_out("t3_stall", 1'b0, 8'd0, 4'd0);
        step(4);
        bus.stall         = 1'b0;
        bus.exception_mem = 1'b1;
        pin_out("t3_exc", 1'b0, 8'd0, 4'd0);
        step(1);
        bus.exception_mem = 1'b0;
        pin_out("t3_clean", 1'b1, 8'd18, 4'b0100);
        step(1);
        bus.irq_src = 4'b0000;
        step(3);
        pulse_mret();
        step(3);

        // 4: edge src0 pulses during a handler are held (and merged), served after mret.
        bus.irq_src = 4'b1000;
        step(3);
        pin_out("t4_src3", 1'b1, 8'd19, 4'b1000);
        step(1);
        bus.irq_src = 4'b0001;
        step(1);
        bus.irq_src = 4'b0000;
        step(2);
        bus.irq_src = 4'b0001;
        step(1);
        bus.irq_src = 4'b0000;
        step(4);
        pin_out("t4_held", 1'b0, 8'd0, 4'd0);
        pulse_mret();
        step(1);
        pin_out("t4_pend", 1'b1, 8'd16, 4'b0001);
        step(4);
        pulse_mret();
        step(5);
        pin_out("t4_merged", 1'b0, 8'd0, 4'd0);
        check("t4_idle", 32'(bus.in_handler), 32'd0);

        // 5: level source drops while armed; then global disable blocks everything.
        bus.inst_valid_mem = 1'b0;
        bus.irq_src        = 4'b0100;
        step(3);
        bus.irq_src = 4'b0000;
        step(5);
        bus.inst_valid_mem = 1'b1;
        step(2);
        pin_out("t5_dropped", 1'b0, 8'd0, 4'd0);
        bus.mie_global = 1'b0;
        bus.irq_src    = 4'b0100;
        step(6);
        pin_out("t5_mie_off", 1'b0, 8'd0, 4'd0);
        check("t5_in_handler", 32'(bus.in_handler), 32'd0);
        bus.irq_src    = 4'b0000;
        bus.mie_global = 1'b1;
        step(4);

        // 6: async reset inside the handler clears state and pending edge.
        bus.irq_src = 4'b1000;
        step(4);
        bus.irq_src = 4'b0001;
        step(1);
        bus.irq_src = 4'b0000;
        step(4);
        #2 rst = 1'b1;
        #1 check("t6_async", 32'(bus.in_handler), 32'd0);
        step(1);
        rst = 1'b0;
        step(6);
        pin_out("t6_after", 1'b0, 8'd0, 4'd0);
        check("t6_in_handler", 32'(bus.in_handler), 32'd0);

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) bus.irq_src[b] = ~bus.irq_src[b];
            end
            if ($urandom_range(0, 31) == 0) bus.irq_enable = 4'($urandom);
            bus.mie_global     = ($urandom_range(0, 15) != 0);
            bus.inst_valid_mem = ($urandom_range(0, 3) != 0);
            bus.stall          = ($urandom_range(0, 3) == 0);
            bus.exception_mem  = ($urandom_range(0, 7) == 0);
            bus.mret           = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #1 rst = 1'b1;
                #3 rst = 1'b0;
            end
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
